// File: rtl/code38_seq.sv
// ----------------------------------------------------------------------------
// code38_seq : FIFO-buffered 3-to-8 decoder replaying codes as active-low
//              one-hot strobes with programmable hold and gap.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module code38_seq #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [2:0]               DIN,
  input  logic                     DIN_VALID,
  output logic                     DIN_READY,
  output logic [7:0]               DOUT,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (CMAX > 2) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] c_HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] c_GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_dout, w_dout_nxt;
  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          r_ready_en;
  logic          w_push, w_pop, w_has;
  logic [7:0]    w_dec;

  // r_ready_en keeps DIN_READY low through reset and until the first edge after release
  assign w_has     = (r_count != '0);
  assign DIN_READY = r_ready_en && (r_count < c_DEPTH);
  assign w_push    = DIN_VALID && DIN_READY;
  assign w_dec     = ~(8'h80 >> r_mem[r_rd]);
  assign DOUT      = r_dout;
  assign COUNT     = r_count;
  assign BUSY      = (r_state != S_IDLE) || w_has;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_dout_nxt = 8'hFF;
        if (w_has) begin
          w_pop       = 1'b1;
          w_dout_nxt  = w_dec;
          w_cnt_nxt   = c_HOLD_LD;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_cnt == '0) begin
          if (GAP > 0) begin
            w_dout_nxt  = 8'hFF;
            w_cnt_nxt   = c_GAP_LD;
            w_state_nxt = S_GAP;
          end else if (w_has) begin
            w_pop      = 1'b1;
            w_dout_nxt = w_dec;
            w_cnt_nxt  = c_HOLD_LD;
          end else begin
            w_dout_nxt  = 8'hFF;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          if (w_has) begin
            w_pop       = 1'b1;
            w_dout_nxt  = w_dec;
            w_cnt_nxt   = c_HOLD_LD;
            w_state_nxt = S_DRIVE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dout_nxt  = 8'hFF;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_dout     <= 8'hFF;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dout     <= w_dout_nxt;
      r_ready_en <= 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when COUNT says they are valid
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= DIN;
  end

endmodule

`default_nettype wire

// File: tb/tb_code38_seq.sv
// ----------------------------------------------------------------------------
// tb_code38_seq : self-checking bench for code38_seq, schedule-based model.
//                 Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_code38_seq;

  localparam int HOLD  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] DIN = '0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [7:0] DOUT;
  logic       BUSY;
  logic [2:0] COUNT;

  logic [2:0] d2_din = '0;
  logic       d2_valid = 1'b0;
  logic       d2_ready;
  logic [7:0] d2_dout;
  logic       d2_busy;
  logic [2:0] d2_count;

  code38_seq #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .DOUT(DOUT), .BUSY(BUSY), .COUNT(COUNT)
  );

  code38_seq #(.HOLD(1), .GAP(0), .DEPTH(4)) u_dut_b2b (
    .CLK(CLK), .RST(RST), .DIN(d2_din), .DIN_VALID(d2_valid), .DIN_READY(d2_ready),
    .DOUT(d2_dout), .BUSY(d2_busy), .COUNT(d2_count)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int free_edge = -100;
  logic [2:0] q_code [$];
  int         q_a [$];
  int         q_p [$];
  logic [7:0] seen [$];
  logic [7:0] prev_dout = 8'hFF;
  logic [7:0] tbl [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // Model: each accepted code gets a strobe start edge P = max(accept+1, previous P+HOLD+GAP)
  function automatic int count_after(input int e);
    int n = 0;
    foreach (q_a[i]) begin
      if (q_a[i] <= e) n++;
      if (q_p[i] <= e) n--;
    end
    return n;
  endfunction

  function automatic logic [7:0] decode(input logic [2:0] c);
    logic [7:0] r;
    r = 8'hFF;
    r[3'd7 - c] = 1'b0;
    return r;
  endfunction

  function automatic logic [2:0] enc83(input logic [7:0] d);
    for (int i = 0; i < 8; i++) if (d[i] == 1'b0) return 3'(7 - i);
    return 3'd0;
  endfunction

  function automatic logic [7:0] exp_dout(input int e);
    foreach (q_p[i]) if (q_p[i] <= e && e < q_p[i] + HOLD) return decode(q_code[i]);
    return 8'hFF;
  endfunction

  function automatic logic exp_busy(input int e);
    if (count_after(e) != 0) return 1'b1;
    foreach (q_p[i]) if (q_p[i] <= e && e < q_p[i] + HOLD + GAP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_ready(input int e);
    return (e >= 1) && (count_after(e) < DEPTH);
  endfunction

  task automatic model_clear();
    q_code.delete(); q_a.delete(); q_p.delete(); seen.delete();
    edge_n = 0; free_edge = -100; prev_dout = 8'hFF;
  endtask

  task automatic new_scenario();
    q_code.delete(); q_a.delete(); q_p.delete(); seen.delete();
  endtask

  task automatic step(input logic v, input logic [2:0] d, output logic acc);
    int p;
    DIN_VALID = v;
    DIN = v ? d : 3'($urandom);
    acc = v && exp_ready(edge_n);
    @(posedge CLK);
    edge_n++;
    if (acc) begin
      p = (edge_n + 1 > free_edge) ? edge_n + 1 : free_edge;
      q_code.push_back(d); q_a.push_back(edge_n); q_p.push_back(p);
      free_edge = p + HOLD + GAP;
    end
    #1;
    if (DOUT !== 8'hFF && prev_dout === 8'hFF) seen.push_back(DOUT);
    prev_dout = DOUT;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic test_reset();
    logic acc;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (DOUT !== 8'hFF) begin failures++; $display("FAIL rst_dout got=%h exp=ff", DOUT); end
    checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", DIN_READY); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    checks++; if (COUNT !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", COUNT); end
    release_reset();
    checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL rel_ready_pre got=%b exp=0", DIN_READY); end
    step(1'b0, 3'd0, acc);
    checks++; if (DIN_READY !== 1'b1) begin failures++; $display("FAIL rel_ready_post got=%b exp=1", DIN_READY); end
    checks++; if (COUNT !== 3'd0 || BUSY !== 1'b0) begin failures++; $display("FAIL rel_idle count=%0d busy=%b exp=0/0", COUNT, BUSY); end
  endtask

  task automatic test_single();
    logic acc;
    new_scenario();
    step(1'b1, 3'd3, acc);
    checks++; if (DOUT !== 8'hFF || COUNT !== 3'd1 || BUSY !== 1'b1) begin
      failures++; $display("FAIL single_push dout=%h count=%0d busy=%b exp=ff/1/1", DOUT, COUNT, BUSY); end
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 3'd0, acc);
      checks++; if (DOUT !== ((i <= HOLD) ? 8'hEF : 8'hFF)) begin
        failures++; $display("FAIL single_dout i=%0d got=%h exp=%h", i, DOUT, (i <= HOLD) ? 8'hEF : 8'hFF); end
      checks++; if (BUSY !== (i <= HOLD + GAP)) begin
        failures++; $display("FAIL single_busy i=%0d got=%b exp=%b", i, BUSY, (i <= HOLD + GAP)); end
    end
  endtask

  task automatic test_all_codes();
    logic acc;
    int nxt = 0;
    new_scenario();
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (nxt == 8 && !exp_busy(edge_n)) break;
      step(nxt < 8, 3'(nxt), acc);
      if (acc) nxt++;
      checks++; if (DOUT !== exp_dout(edge_n)) begin failures++; $display("FAIL codes_dout e=%0d got=%h exp=%h", edge_n, DOUT, exp_dout(edge_n)); end
      checks++; if (COUNT !== 3'(count_after(edge_n))) begin failures++; $display("FAIL codes_count e=%0d got=%0d exp=%0d", edge_n, COUNT, count_after(edge_n)); end
      checks++; if (DIN_READY !== exp_ready(edge_n)) begin failures++; $display("FAIL codes_ready e=%0d got=%b exp=%b", edge_n, DIN_READY, exp_ready(edge_n)); end
      checks++; if (BUSY !== exp_busy(edge_n)) begin failures++; $display("FAIL codes_busy e=%0d got=%b exp=%b", edge_n, BUSY, exp_busy(edge_n)); end
    end
    checks++; if (nxt != 8 || BUSY !== 1'b0) begin failures++; $display("FAIL codes_timeout pushed=%0d busy=%b exp=8/0", nxt, BUSY); end
    checks++; if (seen.size() != 8) begin failures++; $display("FAIL codes_nstrobes got=%0d exp=8", seen.size()); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== tbl[i]) begin failures++; $display("FAIL codes_table i=%0d got=%h exp=%h", i, seen[i], tbl[i]); end
      checks++; if (enc83(seen[i]) !== 3'(i)) begin failures++; $display("FAIL codes_enc i=%0d got=%0d exp=%0d", i, enc83(seen[i]), i); end
    end
  endtask

  task automatic test_full();
    logic acc;
    int nxt = 1;
    new_scenario();
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (nxt == 8 && !exp_busy(edge_n)) break;
      step(nxt < 8, 3'(nxt), acc);
      if (acc) nxt++;
      checks++; if (DOUT !== exp_dout(edge_n)) begin failures++; $display("FAIL full_dout e=%0d got=%h exp=%h", edge_n, DOUT, exp_dout(edge_n)); end
      checks++; if (COUNT !== 3'(count_after(edge_n))) begin failures++; $display("FAIL full_count e=%0d got=%0d exp=%0d", edge_n, COUNT, count_after(edge_n)); end
      checks++; if (DIN_READY !== exp_ready(edge_n)) begin failures++; $display("FAIL full_ready e=%0d got=%b exp=%b", edge_n, DIN_READY, exp_ready(edge_n)); end
      checks++; if (BUSY !== exp_busy(edge_n)) begin failures++; $display("FAIL full_busy e=%0d got=%b exp=%b", edge_n, BUSY, exp_busy(edge_n)); end
    end
    DIN_VALID = 1'b0;
    checks++; if (nxt != 8 || seen.size() != 7) begin failures++; $display("FAIL full_total pushed=%0d strobes=%0d exp=8/7", nxt, seen.size()); end
    for (int i = 0; i < 7 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== decode(3'(i + 1))) begin failures++; $display("FAIL full_order i=%0d got=%h exp=%h", i, seen[i], decode(3'(i + 1))); end
    end
  endtask

  task automatic test_stream();
    logic acc;
    int nxt = 0;
    logic [2:0] code = 3'($urandom);
    new_scenario();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (nxt == 3 * DEPTH && !exp_busy(edge_n)) break;
      step((nxt < 3 * DEPTH) && ($urandom_range(0, 3) != 0), code, acc);
      if (acc) begin nxt++; code = 3'($urandom); end
      checks++; if (DOUT !== exp_dout(edge_n)) begin failures++; $display("FAIL stream_dout e=%0d got=%h exp=%h", edge_n, DOUT, exp_dout(edge_n)); end
      checks++; if (COUNT !== 3'(count_after(edge_n))) begin failures++; $display("FAIL stream_count e=%0d got=%0d exp=%0d", edge_n, COUNT, count_after(edge_n)); end
      checks++; if (DIN_READY !== exp_ready(edge_n)) begin failures++; $display("FAIL stream_ready e=%0d got=%b exp=%b", edge_n, DIN_READY, exp_ready(edge_n)); end
      checks++; if (BUSY !== exp_busy(edge_n)) begin failures++; $display("FAIL stream_busy e=%0d got=%b exp=%b", edge_n, BUSY, exp_busy(edge_n)); end
    end
    checks++; if (nxt != 3 * DEPTH || seen.size() != 3 * DEPTH) begin
      failures++; $display("FAIL stream_total pushed=%0d strobes=%0d exp=%0d", nxt, seen.size(), 3 * DEPTH); end
    for (int i = 0; i < seen.size() && i < q_code.size(); i++) begin
      checks++; if (seen[i] !== decode(q_code[i])) begin failures++; $display("FAIL stream_order i=%0d got=%h exp=%h", i, seen[i], decode(q_code[i])); end
    end
  endtask

  task automatic test_mid_reset();
    logic acc;
    new_scenario();
    step(1'b1, 3'd5, acc);
    step(1'b1, 3'd2, acc);
    DIN_VALID = 1'b0;
    checks++; if (DOUT !== 8'hFB) begin failures++; $display("FAIL midrst_strobe got=%h exp=fb", DOUT); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (DOUT !== 8'hFF) begin failures++; $display("FAIL midrst_dout got=%h exp=ff", DOUT); end
    checks++; if (COUNT !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", COUNT); end
    checks++; if (DIN_READY !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL midrst_rdy_busy got=%b/%b exp=0/0", DIN_READY, BUSY); end
    @(posedge CLK);
    release_reset();
    checks++; if (DIN_READY !== 1'b0) begin failures++; $display("FAIL midrst_rel_pre got=%b exp=0", DIN_READY); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'd0, acc);
      checks++; if (DIN_READY !== 1'b1) begin failures++; $display("FAIL midrst_rel_ready i=%0d got=%b exp=1", i, DIN_READY); end
      checks++; if (DOUT !== 8'hFF || COUNT !== 3'd0 || BUSY !== 1'b0) begin
        failures++; $display("FAIL midrst_discard i=%0d dout=%h count=%0d busy=%b exp=ff/0/0", i, DOUT, COUNT, BUSY); end
    end
  endtask

  task automatic test_back_to_back();
    d2_valid = 1'b1; d2_din = 3'd6;
    @(posedge CLK); #1;
    checks++; if (d2_dout !== 8'hFF || d2_count !== 3'd1) begin failures++; $display("FAIL b2b_push dout=%h count=%0d exp=ff/1", d2_dout, d2_count); end
    d2_din = 3'd7;
    @(posedge CLK); #1;
    d2_valid = 1'b0; d2_din = 3'($urandom);
    checks++; if (d2_dout !== 8'hFD || d2_count !== 3'd1) begin failures++; $display("FAIL b2b_first dout=%h count=%0d exp=fd/1", d2_dout, d2_count); end
    @(posedge CLK); #1;
    checks++; if (d2_dout !== 8'hFE || d2_count !== 3'd0) begin failures++; $display("FAIL b2b_second dout=%h count=%0d exp=fe/0", d2_dout, d2_count); end
    @(posedge CLK); #1;
    checks++; if (d2_dout !== 8'hFF || d2_busy !== 1'b0) begin failures++; $display("FAIL b2b_end dout=%h busy=%b exp=ff/0", d2_dout, d2_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_codes();
    test_full();
    test_stream();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time=%0t exp=finish_before_limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
